// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side request and execute-side decoded bundle of the decode stage
interface decode_stage_if #(
  parameter int IMM_W = 32,
  parameter int ALU_OP_W = 5,
  parameter int CNT_W = 16
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [ALU_OP_W-1:0] alu_op;
  logic [IMM_W-1:0] imm;
  logic [4:0] rs1, rs2, rd;
  logic is_from_rf, rf_we, mem_we, mem_re, branch, is_invert, jump, illegal;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output in_valid, in_instr, out_ready,
    input in_ready, out_valid, alu_op, imm, rs1, rs2, rd, is_from_rf, rf_we, mem_we, mem_re,
    branch, is_invert, jump, illegal, stall_cnt
  );
  modport slave (
    input in_valid, in_instr, out_ready,
    output in_ready, out_valid, alu_op, imm, rs1, rs2, rd, is_from_rf, rf_we, mem_we, mem_re,
    branch, is_invert, jump, illegal, stall_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder with valid/ready handshakes and load-use bubbles
module decode_stage #(
  parameter int IMM_W = 32,
  parameter int ALU_OP_W = 5,
  parameter int EN_LOAD = 1,
  parameter int EN_JUMP = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  decode_stage_if.slave bus
);
  localparam logic [6:0] OPC_IMM = 7'b0010011, OPC_OP = 7'b0110011, OPC_LOAD = 7'b0000011,
    OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011, OPC_LUI = 7'b0110111, OPC_JAL = 7'b1101111;
  logic [31:0] ins;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [3:0] base_alu, d_alu;
  logic [IMM_W-1:0] d_imm;
  logic d_from_rf, d_rf_we, d_mem_we, d_mem_re, d_branch, d_inv, d_jump, d_illegal, d_lui;
  logic reads_rs1, reads_rs2, tag_v, hazard, free, xfer, valid;
  logic [4:0] tag_rd;
  logic [CNT_W-1:0] cnt;
  assign ins = bus.in_instr;
  assign opc = ins[6:0];
  assign f3 = ins[14:12];
  assign f7 = ins[31:25];
  always_comb begin
    case (f3)
      3'b000: base_alu = 4'h1;
      3'b001: base_alu = 4'h7;
      3'b010: base_alu = 4'hA;
      3'b011: base_alu = 4'h6;
      3'b100: base_alu = 4'h2;
      3'b101: base_alu = 4'h8;
      3'b110: base_alu = 4'h3;
      default: base_alu = 4'h4;
    endcase
  end
  always_comb begin
    d_alu = '0;
    d_imm = '0;
    d_from_rf = 1'b0;
    d_rf_we = 1'b0;
    d_mem_we = 1'b0;
    d_mem_re = 1'b0;
    d_branch = 1'b0;
    d_inv = 1'b0;
    d_jump = 1'b0;
    d_lui = 1'b0;
    d_illegal = 1'b0;
    case (opc)
      OPC_IMM: begin
        d_rf_we = 1'b1;
        d_imm = IMM_W'($signed(ins[31:20]));
        d_alu = (f3 == 3'b101 && f7 == 7'b0100000) ? 4'h9 : base_alu;
        d_illegal = (f3 == 3'b001 && f7 != 7'b0) || (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
      end
      OPC_OP: begin
        d_rf_we = 1'b1;
        d_from_rf = 1'b1;
        d_alu = (f7 == 7'b0100000) ? (f3 == 3'b000 ? 4'h5 : 4'h9) : base_alu;
        d_illegal = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_LOAD: begin
        d_illegal = f3 != 3'b010 || EN_LOAD == 0;
        d_alu = 4'h1;
        d_rf_we = 1'b1;
        d_mem_re = 1'b1;
        d_imm = IMM_W'($signed(ins[31:20]));
      end
      OPC_STORE: begin
        d_illegal = f3 != 3'b010;
        d_alu = 4'h1;
        d_mem_we = 1'b1;
        d_imm = IMM_W'($signed({ins[31:25], ins[11:7]}));
      end
      OPC_BRANCH: begin
        d_illegal = f3[2:1] == 2'b01;
        d_branch = 1'b1;
        d_from_rf = 1'b1;
        d_imm = IMM_W'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        d_alu = f3[2] ? (f3[1] ? 4'h6 : 4'hA) : 4'h2;
        d_inv = f3[2] ? f3[0] : !f3[0];
      end
      OPC_LUI: begin
        d_illegal = EN_JUMP == 0;
        d_lui = 1'b1;
        d_rf_we = 1'b1;
        d_alu = 4'h1;
        d_imm = IMM_W'({ins[31:12], 12'b0});
      end
      OPC_JAL: begin
        d_illegal = EN_JUMP == 0;
        d_jump = 1'b1;
        d_rf_we = 1'b1;
        d_imm = IMM_W'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      default: d_illegal = 1'b1;
    endcase
    if (d_illegal) begin
      d_alu = '0;
      d_imm = '0;
      {d_from_rf, d_rf_we, d_mem_we, d_mem_re, d_branch, d_inv, d_jump, d_lui} = '0;
    end
  end
  assign reads_rs1 = opc inside {OPC_IMM, OPC_OP, OPC_LOAD, OPC_STORE, OPC_BRANCH};
  assign reads_rs2 = opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  // tag_rd is never x0 while tag_v is set, so x0 readers cannot hazard
  assign hazard = tag_v && bus.in_valid &&
    ((reads_rs1 && ins[19:15] == tag_rd) || (reads_rs2 && ins[24:20] == tag_rd));
  assign free = !valid || bus.out_ready;
  assign bus.in_ready = free && !hazard;
  assign xfer = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid;
  assign bus.stall_cnt = cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      cnt <= '0;
      tag_v <= 1'b0;
      tag_rd <= '0;
      bus.alu_op <= '0;
      bus.imm <= '0;
      {bus.rs1, bus.rs2, bus.rd} <= '0;
      {bus.is_from_rf, bus.rf_we, bus.mem_we, bus.mem_re, bus.branch, bus.is_invert, bus.jump, bus.illegal} <= '0;
    end else if (xfer) begin
      valid <= 1'b1;
      tag_v <= d_mem_re && ins[11:7] != 5'd0;
      tag_rd <= ins[11:7];
      bus.alu_op <= ALU_OP_W'(d_alu);
      bus.imm <= d_imm;
      bus.rs1 <= d_lui ? 5'd0 : ins[19:15];
      bus.rs2 <= ins[24:20];
      bus.rd <= ins[11:7];
      {bus.is_from_rf, bus.rf_we, bus.mem_we, bus.mem_re, bus.branch, bus.is_invert, bus.jump, bus.illegal} <=
        {d_from_rf, d_rf_we, d_mem_we, d_mem_re, d_branch, d_inv, d_jump, d_illegal};
    end else if (free) begin
      valid <= 1'b0;
      if (hazard) begin
        tag_v <= 1'b0;
        cnt <= &cnt ? cnt : cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven decode checks plus handshake, hazard and parameter sequences
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  decode_stage_if b ();
  decode_stage_if #(.IMM_W(12), .CNT_W(2)) p ();
  decode_stage_if q ();
  assign p.in_valid = b.in_valid;
  assign p.in_instr = b.in_instr;
  assign p.out_ready = b.out_ready;
  assign q.in_valid = b.in_valid;
  assign q.in_instr = b.in_instr;
  assign q.out_ready = b.out_ready;
  decode_stage dut (.clk(clk), .rst_n(rst_n), .bus(b));
  decode_stage #(.IMM_W(12), .CNT_W(2)) dut_p (.clk(clk), .rst_n(rst_n), .bus(p));
  decode_stage #(.EN_JUMP(0)) dut_q (.clk(clk), .rst_n(rst_n), .bus(q));
  typedef struct packed {
    logic [31:0] instr;
    logic [3:0] alu;
    logic [31:0] imm;
    logic [7:0] fl;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] chk;
  } vec_t;
  localparam logic [31:0] I_ADDI = 32'hFFB00093, I_BEQ = 32'hFE208CE3, I_LW5 = 32'h00412283,
    I_ADD65 = 32'h00128333, I_LW0 = 32'h00412003, I_ADD601 = 32'h00100333;
  vec_t tv [14];
  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] flags;
    return {b.is_from_rf, b.rf_we, b.mem_we, b.mem_re, b.branch, b.is_invert, b.jump, b.illegal};
  endfunction
  task automatic load_use;
    b.in_instr = I_LW5;
    tick();
    chk("lu_lw_mem_re", b.mem_re, 1);
    b.in_instr = I_ADD65;
    #1;
    chk("lu_in_ready_low", b.in_ready, 0);
    tick();
    chk("lu_bubble_valid", b.out_valid, 0);
    chk("lu_in_ready_after", b.in_ready, 1);
    tick();
    chk("lu_add_valid", b.out_valid, 1);
    chk("lu_add_rd", b.rd, 6);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{32'hFFB00093, 4'h1, 32'hFFFFFFFB, 8'b0100_0000, 5'd0, 5'd27, 5'd1, 2'b11};
    tv[1]  = '{32'h402081B3, 4'h5, 32'h0, 8'b1100_0000, 5'd1, 5'd2, 5'd3, 2'b10};
    tv[2]  = '{32'h7FF1C213, 4'h2, 32'h7FF, 8'b0100_0000, 5'd3, 5'd31, 5'd4, 2'b11};
    tv[3]  = '{32'h40335293, 4'h9, 32'h403, 8'b0100_0000, 5'd6, 5'd3, 5'd5, 2'b11};
    tv[4]  = '{32'h009433B3, 4'h6, 32'h0, 8'b1100_0000, 5'd8, 5'd9, 5'd7, 2'b10};
    tv[5]  = '{32'hFE512E23, 4'h1, 32'hFFFFFFFC, 8'b0010_0000, 5'd2, 5'd5, 5'd28, 2'b11};
    tv[6]  = '{32'h0041E863, 4'h6, 32'h10, 8'b1000_1000, 5'd3, 5'd4, 5'd16, 2'b11};
    tv[7]  = '{32'h12345537, 4'h1, 32'h12345000, 8'b0100_0000, 5'd0, 5'd3, 5'd10, 2'b11};
    tv[8]  = '{32'h00412283, 4'h1, 32'h4, 8'b0101_0000, 5'd2, 5'd4, 5'd5, 2'b11};
    tv[9]  = '{32'h001000EF, 4'h0, 32'h800, 8'b0100_0010, 5'd0, 5'd1, 5'd1, 2'b01};
    tv[10] = '{32'h00000000, 4'h0, 32'h0, 8'b0000_0001, 5'd0, 5'd0, 5'd0, 2'b00};
    tv[11] = '{32'h40109093, 4'h0, 32'h0, 8'b0000_0001, 5'd1, 5'd1, 5'd1, 2'b00};
    tv[12] = '{32'h00002063, 4'h0, 32'h0, 8'b0000_0001, 5'd0, 5'd0, 5'd0, 2'b00};
    tv[13] = '{32'h02000033, 4'h0, 32'h0, 8'b0000_0001, 5'd0, 5'd0, 5'd0, 2'b00};
    b.out_ready = 1'b1;
    b.in_valid = 1'b1;
    b.in_instr = tv[0].instr;
    repeat (2) tick();
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_stall_cnt", b.stall_cnt, 0);
    chk("rst_flags", flags(), 0);
    chk("rst_imm", b.imm, 0);
    chk("rst_alu_op", b.alu_op, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      b.in_instr = tv[i].instr;
      #1;
      chk($sformatf("v%0d_in_ready", i), b.in_ready, 1);
      tick();
      chk($sformatf("v%0d_out_valid", i), b.out_valid, 1);
      chk($sformatf("v%0d_flags", i), flags(), tv[i].fl);
      chk($sformatf("v%0d_regs", i), {b.rs1, b.rs2, b.rd}, {tv[i].rs1, tv[i].rs2, tv[i].rd});
      if (tv[i].chk[1]) chk($sformatf("v%0d_alu_op", i), b.alu_op, {1'b0, tv[i].alu});
      if (tv[i].chk[0]) chk($sformatf("v%0d_imm", i), b.imm, tv[i].imm);
      if (tv[i].instr[6:0] == 7'b0110111) begin
        chk("p_lui_imm12", p.imm, 0);
        chk("p_lui_legal", p.illegal, 0);
      end
      if (tv[i].instr[6:0] == 7'b1101111) begin
        chk("q_jal_illegal", q.illegal, 1);
        chk("q_jal_enables", {q.jump, q.rf_we}, 0);
        chk("q_jal_valid", q.out_valid, 1);
      end
    end
    b.in_valid = 1'b0;
    tick();
    chk("idle_out_valid", b.out_valid, 0);
    b.in_valid = 1'b1;
    b.in_instr = I_BEQ;
    tick();
    b.out_ready = 1'b0;
    b.in_instr = I_ADDI;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_in_ready", b.in_ready, 0);
      chk("bp_out_valid", b.out_valid, 1);
      chk("bp_imm", b.imm, 32'hFFFFFFF8);
      chk("bp_invert_alu", {b.is_invert, b.branch, b.alu_op}, {2'b11, 5'h2});
    end
    b.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", b.in_ready, 1);
    tick();
    chk("bp_next_alu", b.alu_op, 1);
    chk("bp_next_imm", b.imm, 32'hFFFFFFFB);
    load_use();
    chk("lu_stall_cnt", b.stall_cnt, 1);
    chk("p_stall_cnt1", p.stall_cnt, 1);
    b.in_instr = I_LW0;
    tick();
    b.in_instr = I_ADD601;
    #1;
    chk("x0_in_ready", b.in_ready, 1);
    tick();
    chk("x0_out_valid", b.out_valid, 1);
    chk("x0_stall_cnt", b.stall_cnt, 1);
    b.in_instr = I_LW5;
    tick();
    b.out_ready = 1'b0;
    b.in_instr = I_ADD65;
    repeat (2) tick();
    chk("ds_stall_cnt", b.stall_cnt, 1);
    chk("ds_hold_lw", {b.out_valid, b.mem_re, b.rd}, {2'b11, 5'd5});
    b.out_ready = 1'b1;
    #1;
    chk("ds_tag_kept", b.in_ready, 0);
    tick();
    chk("ds_bubble", {b.out_valid, b.stall_cnt}, {1'b0, 16'd2});
    tick();
    chk("ds_add_rd", {b.out_valid, b.rd}, {1'b1, 5'd6});
    load_use();
    load_use();
    chk("sat_main_cnt", b.stall_cnt, 4);
    chk("sat_p_cnt", p.stall_cnt, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
